game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_ctrl_if.sv | 15 +
 rtl/rect_overlap.sv | 30 +++
 rtl/game_ctrl.sv | 128 ++++++++++++
 tb/tb_game_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants for the coin-collection game controller
package game_pkg;

    localparam int N_SLOTS      = 3;
    localparam int DEF_PLAYER_W = 120;
    localparam int DEF_PLAYER_H = 40;
    localparam int DEF_COIN_SZ  = 50;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_OVER  = 3'd3;

    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [1:0] slot);
        case (slot)
            2'd0:    slot_onehot = 3'b001;
            2'd1:    slot_onehot = 3'b010;
            2'd2:    slot_onehot = 3'b100;
            default: slot_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - player/coin position bus and coin retire strobes
interface game_ctrl_if;
    import game_pkg::*;

    logic [9:0]           playerX;
    logic [8:0]           playerY;
    logic [10*N_SLOTS-1:0] coinsX;
    logic [9*N_SLOTS-1:0]  coinsY;
    logic [2*N_SLOTS-1:0]  coins;
    logic [N_SLOTS-1:0]    coin_clr;

    modport master (output playerX, playerY, coinsX, coinsY, coins, input coin_clr);
    modport slave  (input playerX, playerY, coinsX, coinsY, coins, output coin_clr);

endinterface

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational overlap test between the player box and one coin square
module rect_overlap #(
    parameter int A_W  = 120,
    parameter int A_H  = 40,
    parameter int B_SZ = 50
) (
    input  logic       active,
    input  logic [9:0] ax,
    input  logic [8:0] ay,
    input  logic [9:0] bx,
    input  logic [8:0] by,
    output logic       overlap
);
    localparam logic [10:0] AW = 11'(A_W);
    localparam logic [10:0] AH = 11'(A_H);
    localparam logic [10:0] BS = 11'(B_SZ);

    // 11-bit operands so edge sums near the screen limit cannot wrap
    logic [10:0] ax_e, ay_e, bx_e, by_e;

    assign ax_e = {1'b0, ax};
    assign ay_e = {2'b00, ay};
    assign bx_e = {1'b0, bx};
    assign by_e = {2'b00, by};

    assign overlap = active
                  && (ax_e < bx_e + BS) && (bx_e < ax_e + AW)
                  && (ay_e < by_e + BS) && (by_e < ay_e + AH);

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game FSM: per-frame coin collection scan, score and lives bookkeeping
module game_ctrl
    import game_pkg::*;
#(
    parameter int PLAYER_W   = DEF_PLAYER_W,
    parameter int PLAYER_H   = DEF_PLAYER_H,
    parameter int COIN_SZ    = DEF_COIN_SZ,
    parameter int LIVES_INIT = 3
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        hit,
    game_ctrl_if.slave  bus,
    output logic        run_en,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic        game_over,
    output logic [2:0]  state
);
    localparam logic [2:0] LIVES_LD = 3'(LIVES_INIT);
    localparam logic [1:0] LAST_SLOT = 2'(N_SLOTS - 1);

    logic [1:0]  slot, slot_d;
    logic [2:0]  state_d, lives_d;
    logic [15:0] score_d;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic        c_act, overlap, in_play, lose;

    // one comparator shared across slots; CHECK walks the slot index
    always_comb begin
        cx    = bus.coinsX[9:0];
        cy    = bus.coinsY[8:0];
        c_act = |bus.coins[1:0];
        case (slot)
            2'd1: begin
                cx    = bus.coinsX[19:10];
                cy    = bus.coinsY[17:9];
                c_act = |bus.coins[3:2];
            end
            2'd2: begin
                cx    = bus.coinsX[29:20];
                cy    = bus.coinsY[26:18];
                c_act = |bus.coins[5:4];
            end
            default: ;
        endcase
    end

    rect_overlap #(
        .A_W  (PLAYER_W),
        .A_H  (PLAYER_H),
        .B_SZ (COIN_SZ)
    ) u_overlap (
        .active  (c_act),
        .ax      (bus.playerX),
        .ay      (bus.playerY),
        .bx      (cx),
        .by      (cy),
        .overlap (overlap)
    );

    assign in_play = (state == ST_RUN) || (state == ST_CHECK);
    assign lose    = in_play && hit && (lives == 3'd1);

    always_comb begin
        state_d = state;
        slot_d  = slot;
        score_d = score;
        lives_d = lives;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    lives_d = LIVES_LD;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    state_d = ST_CHECK;
                    slot_d  = 2'd0;
                end
            end
            ST_CHECK: begin
                if (overlap && score != 16'hFFFF)
                    score_d = score + 16'd1;
                if (slot == LAST_SLOT) begin
                    state_d = ST_RUN;
                    slot_d  = 2'd0;
                end else begin
                    slot_d = slot + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_play && hit && lives != 3'd0)
            lives_d = lives - 3'd1;
        // losing the last life aborts the scan; the current slot's result still lands
        if (lose) begin
            state_d = ST_OVER;
            slot_d  = 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state        <= ST_IDLE;
            slot         <= 2'd0;
            score        <= '0;
            lives        <= '0;
            bus.coin_clr <= '0;
            run_en       <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_d;
            slot         <= slot_d;
            score        <= score_d;
            lives        <= lives_d;
            bus.coin_clr <= (state == ST_CHECK && overlap) ? slot_onehot(slot) : '0;
            run_en       <= (state_d == ST_RUN) || (state_d == ST_CHECK);
            game_over    <= (state_d == ST_OVER);
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed bench for game_ctrl with a queue-based reference model
module tb_game_ctrl;
    import game_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_BTN, start, frame_tick, hit;
    logic        run_en, game_over;
    logic [15:0] score;
    logic [2:0]  lives, state;

    int checks = 0;
    int errors = 0;

    game_ctrl_if gif();

    game_ctrl dut (
        .CLK        (CLK),
        .RST_BTN    (RST_BTN),
        .start      (start),
        .frame_tick (frame_tick),
        .hit        (hit),
        .bus        (gif),
        .run_en     (run_en),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    // reference model: a frame schedules a list of slots to scan, one per clock
    logic [2:0] m_state = ST_IDLE;
    logic [2:0] m_clr   = 3'b000;
    int         m_score = 0;
    int         m_lives = 0;
    int         pend[$];

    function automatic bit coin_hit(int s);
        int px, py, cx, cy;
        px = int'(gif.playerX);
        py = int'(gif.playerY);
        cx = int'(gif.coinsX[s*10 +: 10]);
        cy = int'(gif.coinsY[s*9 +: 9]);
        return (gif.coins[s*2 +: 2] != 2'b00) && px < cx + 50 && cx < px + 120
               && py < cy + 50 && cy < py + 40;
    endfunction

    initial forever begin
        bit         playing;
        logic [2:0] nclr;
        int         s;
        @(posedge CLK or negedge RST_BTN);
        if (!RST_BTN) begin
            m_state = ST_IDLE;
            pend.delete();
            m_score = 0;
            m_lives = 0;
            m_clr   = 3'b000;
        end else begin
            playing = (m_state == ST_RUN) || (m_state == ST_CHECK);
            nclr    = 3'b000;
            if (!playing && start) begin
                m_state = ST_RUN;
                m_score = 0;
                m_lives = 3;
            end else if (m_state == ST_RUN && frame_tick) begin
                pend = {0, 1, 2};
            end else if (pend.size() > 0) begin
                s = pend.pop_front();
                if (coin_hit(s)) begin
                    nclr[s] = 1'b1;
                    if (m_score < 65535) m_score++;
                end
            end
            if (playing && hit) begin
                m_lives--;
                if (m_lives == 0) begin
                    pend.delete();
                    m_state = ST_OVER;
                end
            end
            m_clr = nclr;
            if (m_state == ST_RUN || m_state == ST_CHECK)
                m_state = (pend.size() > 0) ? ST_CHECK : ST_RUN;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        chk("m_state", int'(state), int'(m_state));
        chk("m_score", int'(score), m_score);
        chk("m_lives", int'(lives), m_lives);
        chk("m_coin_clr", int'(gif.coin_clr), int'(m_clr));
        chk("m_run_en", int'(run_en), int'(m_state == ST_RUN || m_state == ST_CHECK));
        chk("m_game_over", int'(game_over), int'(m_state == ST_OVER));
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic set_coin(int s, int x, int y, logic [1:0] code);
        gif.coinsX[s*10 +: 10] = 10'(x);
        gif.coinsY[s*9 +: 9]   = 9'(y);
        gif.coins[s*2 +: 2]    = code;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    initial begin
        RST_BTN = 1'b0; start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        gif.playerX = 10'd100; gif.playerY = 9'd200;
        gif.coinsX = '0; gif.coinsY = '0; gif.coins = '0;
        cyc(2);
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_run_en", int'(run_en), 0);
        RST_BTN = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("idle_tick_ignored", int'(state), 0);

        start = 1'b1; cyc(1); start = 1'b0;
        chk("start_state", int'(state), 1);
        chk("start_run_en", int'(run_en), 1);
        chk("start_lives", int'(lives), 3);

        set_coin(1, 150, 210, 2'b01);
        frame();
        chk("s1_clr_n1", int'(gif.coin_clr), 0);
        cyc(1); chk("s1_clr_n2", int'(gif.coin_clr), 0);
        cyc(1); chk("s1_clr_n3", int'(gif.coin_clr), 2);
        chk("s1_score", int'(score), 1);
        cyc(1); chk("s1_clr_n4", int'(gif.coin_clr), 0);
        chk("s1_state_n4", int'(state), 1);

        set_coin(1, 0, 0, 2'b00);
        set_coin(0, 220, 200, 2'b10);
        set_coin(2, 50, 200, 2'b11);
        frame(); cyc(4);
        chk("touch_score", int'(score), 1);

        set_coin(0, 219, 200, 2'b01);
        set_coin(1, 100, 151, 2'b01);
        set_coin(2, 100, 240, 2'b01);
        frame_tick = 1'b1; cyc(1);
        start = 1'b1; cyc(1);
        frame_tick = 1'b0; start = 1'b0; cyc(3);
        chk("edge_score", int'(score), 3);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("run_start_ignored", int'(score), 3);

        hit = 1'b1; cyc(1); hit = 1'b0;
        chk("hit_run_lives", int'(lives), 2);

        frame();
        hit = 1'b1; cyc(1); hit = 1'b0;
        chk("hit_ovl_score", int'(score), 4);
        chk("hit_ovl_lives", int'(lives), 1);
        cyc(3);
        chk("hit_ovl_end_score", int'(score), 5);

        set_coin(0, 0, 0, 2'b00);
        set_coin(2, 130, 220, 2'b01);
        frame();
        hit = 1'b1; cyc(1); hit = 1'b0;
        chk("over_state", int'(state), 3);
        chk("over_game_over", int'(game_over), 1);
        chk("over_run_en", int'(run_en), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("over_no_clr", int'(gif.coin_clr), 0);
        end
        chk("over_score_held", int'(score), 5);
        frame_tick = 1'b1; hit = 1'b1; cyc(1); frame_tick = 1'b0; hit = 1'b0;
        chk("over_hit_ignored", int'(lives), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);

        set_coin(0, 219, 200, 2'b01);
        force dut.score = 16'hFFFE;
        m_score = 65534;
        cyc(1);
        release dut.score;
        chk("preload_score", int'(score), 65534);
        frame(); cyc(1);
        chk("sat_clr0", int'(gif.coin_clr), 1);
        chk("sat_score0", int'(score), 65535);
        cyc(1); chk("sat_clr1", int'(gif.coin_clr), 2);
        cyc(1); chk("sat_clr2", int'(gif.coin_clr), 4);
        chk("sat_score2", int'(score), 65535);

        frame(); cyc(1);
        RST_BTN = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_clr", int'(gif.coin_clr), 0);
        cyc(2);
        RST_BTN = 1'b1;
        cyc(5);
        chk("post_rst_clr", int'(gif.coin_clr), 0);
        chk("post_rst_state", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
